multichan_frame_rx: RTL and testbench

Parametrised receive-side deframer, successor to the multichannel transceiver's receive path. It consumes link words from a serial bridge, validates framing, length, a new per-frame XOR checksum and packet id. Good messages are delivered into per-channel FIFOs of configurable depth. It sits between the UART/link adapter and the CPU-side channel consumers (memory controller, debug port).

---
 rtl/multichan_frame_rx_pkg.sv | 34 +++
 rtl/chan_fifo.sv | 63 ++++++
 rtl/multichan_frame_rx.sv | 250 +++++++++++++++++++++++++
 tb/tb_multichan_frame_rx.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multichan_frame_rx_pkg.sv
// Shared definitions for the multichannel receive deframer: word-class prefixes,
// rejection codes and the deframing FSM state encoding.
package multichan_frame_rx_pkg;

    localparam logic [2:0] PFX_HEAD = 3'b100;
    localparam logic [2:0] PFX_CHAN = 3'b101;
    localparam logic [2:0] PFX_LEN  = 3'b110;
    localparam logic [2:0] PFX_END  = 3'b111;

    localparam logic [2:0] ERR_CLASS = 3'd1;
    localparam logic [2:0] ERR_LEN   = 3'd2;
    localparam logic [2:0] ERR_CSUM  = 3'd3;
    localparam logic [2:0] ERR_ID    = 3'd4;
    localparam logic [2:0] ERR_FULL  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CHAN = 3'd1,
        ST_LEN  = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4,
        ST_END  = 3'd5
    } rx_state_e;

    // Largest legal length field: bounded by the payload store and by the field width.
    function automatic int max_len(input int message_bit, input int len_bit);
        int by_msg;
        int by_field;
        by_msg   = message_bit / 8;
        by_field = (1 << len_bit) - 1;
        return (by_msg < by_field) ? by_msg : by_field;
    endfunction

endpackage

// File: rtl/chan_fifo.sv
// Single-clock first-word-fall-through FIFO; a pop on empty is ignored and a
// push while full is accepted only when a pop frees a slot in the same cycle.
module chan_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH_BIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_BIT;

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [DEPTH_BIT-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BIT-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BIT:0]   count_q, count_d;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (DEPTH_BIT + 1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + (DEPTH_BIT + 1)'(do_push) - (DEPTH_BIT + 1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/multichan_frame_rx.sv
// Receive-side deframer: validates HEAD/CHAN/LEN/DATA/CSUM/END link words and
// delivers good messages as {len, payload} into per-channel FWFT FIFOs.
module multichan_frame_rx
    import multichan_frame_rx_pkg::*;
#(
    parameter int PACKET_SIZE = 8,
    parameter int MESSAGE_BIT = 256,
    parameter int LEN_BIT     = 5,
    parameter int CHANNEL_BIT = 1,
    parameter int DEPTH_BIT   = 2
) (
    input  logic                                                  CLK,
    input  logic                                                  RST,
    input  logic                                                  recv_valid,
    input  logic [PACKET_SIZE-1:0]                                recv_data,
    input  logic [(1<<CHANNEL_BIT)-1:0]                           read_flags,
    output logic [(1<<CHANNEL_BIT)*(MESSAGE_BIT+LEN_BIT)-1:0]     read_datas,
    output logic [(1<<CHANNEL_BIT)-1:0]                           readable,
    output logic                                                  frame_ok,
    output logic                                                  frame_err,
    output logic [2:0]                                            err_code,
    output logic [15:0]                                           drop_count,
    output logic [2:0]                                            dbg_state
);

    localparam int CHANNEL = 1 << CHANNEL_BIT;
    localparam int WORD_W  = MESSAGE_BIT + LEN_BIT;
    localparam int MAX_LEN = max_len(MESSAGE_BIT, LEN_BIT);
    localparam int CNT_W   = 16;

    // recv_valid qualifies recv_data for exactly one cycle; there is no back-pressure.
    rx_state_e            state_q, state_d;
    logic [4:0]           id_q, id_d;
    logic [CHANNEL_BIT-1:0] ch_q, ch_d;
    logic [LEN_BIT-1:0]   len_q, len_d;
    logic [MESSAGE_BIT-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [6:0]           csum_q, csum_d;
    logic                 frame_ok_q, frame_ok_d;
    logic                 frame_err_q, frame_err_d;
    logic [2:0]           err_code_q, err_code_d;
    logic [15:0]          drop_count_q, drop_count_d;

    logic [2:0]           pfx;
    logic                 is_data;
    logic [4:0]           f_id;
    logic [CHANNEL_BIT-1:0] f_ch;
    logic [LEN_BIT-1:0]   f_len;
    logic [6:0]           f_pay;
    logic [CNT_W-1:0]     len_bits;
    logic [CNT_W-1:0]     cnt_next;
    logic [MESSAGE_BIT-1:0] ins_bits;
    logic [MESSAGE_BIT-1:0] pay_mask;
    logic [WORD_W-1:0]    push_word;

    logic [CHANNEL-1:0]   fifo_push;
    logic [CHANNEL-1:0]   fifo_full;
    logic [CHANNEL-1:0]   fifo_empty;
    logic                 can_push;

    logic                 start;
    logic                 class_err;
    logic                 err_ev;
    logic [2:0]           err_val;
    logic                 do_push;

    assign pfx      = recv_data[PACKET_SIZE-1 -: 3];
    assign is_data  = ~recv_data[PACKET_SIZE-1];
    assign f_id     = recv_data[4:0];
    assign f_ch     = recv_data[CHANNEL_BIT-1:0];
    assign f_len    = recv_data[LEN_BIT-1:0];
    assign f_pay    = recv_data[6:0];

    assign len_bits = CNT_W'(len_q) << 3;
    assign cnt_next = cnt_q + CNT_W'(7);
    // Bits of the last DATA word that spill past the store simply fall off the shift.
    assign ins_bits = MESSAGE_BIT'(f_pay) << cnt_q;
    assign pay_mask = ~({MESSAGE_BIT{1'b1}} << len_bits);
    assign push_word = {len_q, buf_q & pay_mask};

    // A pop in the END cycle frees the slot that the push then uses.
    assign can_push = ~fifo_full[ch_q] | (read_flags[ch_q] & ~fifo_empty[ch_q]);

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        ch_d      = ch_q;
        len_d     = len_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        csum_d    = csum_q;
        start     = 1'b0;
        class_err = 1'b0;
        err_ev    = 1'b0;
        err_val   = 3'd0;
        do_push   = 1'b0;

        if (recv_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pfx == PFX_HEAD) begin
                        start = 1'b1;
                    end
                end
                ST_CHAN: begin
                    if (pfx == PFX_CHAN) begin
                        ch_d    = f_ch;
                        state_d = ST_LEN;
                    end else begin
                        class_err = 1'b1;
                    end
                end
                ST_LEN: begin
                    if (pfx == PFX_LEN) begin
                        if ((f_len != '0) && (int'(f_len) <= MAX_LEN)) begin
                            len_d   = f_len;
                            state_d = ST_DATA;
                        end else begin
                            err_ev  = 1'b1;
                            err_val = ERR_LEN;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        class_err = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (is_data) begin
                        buf_d  = buf_q | ins_bits;
                        cnt_d  = cnt_next;
                        csum_d = csum_q ^ f_pay;
                        if (cnt_next >= len_bits) begin
                            state_d = ST_CSUM;
                        end
                    end else begin
                        class_err = 1'b1;
                    end
                end
                ST_CSUM: begin
                    if (is_data) begin
                        if (recv_data == PACKET_SIZE'(csum_q)) begin
                            state_d = ST_END;
                        end else begin
                            err_ev  = 1'b1;
                            err_val = ERR_CSUM;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        class_err = 1'b1;
                    end
                end
                ST_END: begin
                    if (pfx == PFX_END) begin
                        state_d = ST_IDLE;
                        if (f_id != id_q) begin
                            err_ev  = 1'b1;
                            err_val = ERR_ID;
                        end else if (can_push) begin
                            do_push = 1'b1;
                        end else begin
                            err_ev  = 1'b1;
                            err_val = ERR_FULL;
                        end
                    end else begin
                        class_err = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // A stray HEAD is both an error for the old frame and the start of a new one.
            if (class_err) begin
                err_ev  = 1'b1;
                err_val = ERR_CLASS;
                if (pfx == PFX_HEAD) begin
                    start = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            if (start) begin
                id_d    = f_id;
                buf_d   = '0;
                cnt_d   = '0;
                csum_d  = '0;
                state_d = ST_CHAN;
            end
        end

        frame_ok_d   = do_push;
        frame_err_d  = err_ev;
        err_code_d   = err_ev ? err_val : err_code_q;
        drop_count_d = (err_ev && (drop_count_q != 16'hFFFF)) ? drop_count_q + 16'd1 : drop_count_q;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            id_q         <= '0;
            ch_q         <= '0;
            len_q        <= '0;
            buf_q        <= '0;
            cnt_q        <= '0;
            csum_q       <= '0;
            frame_ok_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            err_code_q   <= 3'd0;
            drop_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            ch_q         <= ch_d;
            len_q        <= len_d;
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            csum_q       <= csum_d;
            frame_ok_q   <= frame_ok_d;
            frame_err_q  <= frame_err_d;
            err_code_q   <= err_code_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign fifo_push = do_push ? (CHANNEL'(1) << ch_q) : '0;

    for (genvar k = 0; k < CHANNEL; k++) begin : g_chan
        chan_fifo #(
            .WIDTH    (WORD_W),
            .DEPTH_BIT(DEPTH_BIT)
        ) u_fifo (
            .clk      (CLK),
            .rst_n    (RST),
            .push     (fifo_push[k]),
            .push_data(push_word),
            .pop      (read_flags[k]),
            .head     (read_datas[k*WORD_W +: WORD_W]),
            .full     (fifo_full[k]),
            .empty    (fifo_empty[k])
        );
    end

    assign readable   = ~fifo_empty;
    assign frame_ok   = frame_ok_q;
    assign frame_err  = frame_err_q;
    assign err_code   = err_code_q;
    assign drop_count = drop_count_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_multichan_frame_rx.sv
// Bench for multichan_frame_rx: directed frames plus randomized frames checked
// against a per-channel queue model built from the framing rules.
module tb_multichan_frame_rx;

    localparam int MESSAGE_BIT = 256;
    localparam int LEN_BIT     = 5;
    localparam int CHANNEL     = 2;
    localparam int W           = MESSAGE_BIT + LEN_BIT;
    localparam int DEPTH       = 4;
    localparam int MAX_LEN     = 31;

    logic               CLK = 1'b0;
    logic               RST = 1'b0;
    logic               recv_valid = 1'b0;
    logic [7:0]         recv_data = 8'h00;
    logic [1:0]         read_flags = 2'b00;
    logic [2*W-1:0]     read_datas;
    logic [1:0]         readable;
    logic               frame_ok;
    logic               frame_err;
    logic [2:0]         err_code;
    logic [15:0]        drop_count;
    logic [2:0]         dbg_state;

    int                 checks = 0;
    int                 failures = 0;
    logic [W-1:0]       exp_q [CHANNEL][$];
    logic [2:0]         exp_code = 3'd0;
    int                 exp_drop = 0;
    logic [7:0]         fw [$];
    logic [W-1:0]       fw_word;
    int                 n_ok;
    int                 n_err;

    multichan_frame_rx dut (
        .CLK       (CLK),
        .RST       (RST),
        .recv_valid(recv_valid),
        .recv_data (recv_data),
        .read_flags(read_flags),
        .read_datas(read_datas),
        .readable  (readable),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .drop_count(drop_count),
        .dbg_state (dbg_state)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [299:0] obs, input logic [299:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(inout int ok_c, inout int err_c);
        @(posedge CLK);
        #1;
        if (frame_ok === 1'b1) ok_c++;
        if (frame_err === 1'b1) err_c++;
    endtask

    // Sends fw[] with random idle gaps; optionally pops pop_ch together with the last word.
    task automatic send_seq(input int pop_ch, output int ok_o, output int err_o);
        int ok_c = 0;
        int err_c = 0;
        for (int i = 0; i < fw.size(); i++) begin
            repeat ($urandom_range(0, 1)) begin
                recv_valid = 1'b0;
                recv_data  = 8'($urandom);
                tick(ok_c, err_c);
            end
            recv_valid = 1'b1;
            recv_data  = fw[i];
            if ((i == fw.size() - 1) && (pop_ch >= 0)) read_flags[pop_ch] = 1'b1;
            tick(ok_c, err_c);
            recv_valid = 1'b0;
            read_flags = 2'b00;
        end
        tick(ok_c, err_c);
        ok_o  = ok_c;
        err_o = err_c;
    endtask

    task automatic pop_chan(input int k);
        read_flags[k] = 1'b1;
        @(posedge CLK);
        #1;
        read_flags = 2'b00;
        if (exp_q[k].size() > 0) void'(exp_q[k].pop_front());
    endtask

    task automatic check_outputs(input string tag);
        for (int k = 0; k < CHANNEL; k++) begin
            chk({tag, "_readable"}, readable[k], exp_q[k].size() > 0);
            if (exp_q[k].size() > 0) chk({tag, "_head"}, read_datas[k*W +: W], exp_q[k][0]);
        end
        chk({tag, "_err_code"}, err_code, exp_code);
        chk({tag, "_drop_count"}, drop_count, exp_drop);
    endtask

    // kind: 0 good, 1 bad checksum, 2 bad END id, 3 zero length, 4 wrong word class in DATA
    task automatic build_frame(input int kind, input logic [4:0] id, input logic ch,
                               input int len, input logic [255:0] pay);
        int n;
        int bad_pos;
        logic [6:0] cs;
        logic [6:0] b;
        logic [255:0] mask;
        fw.delete();
        fw.push_back({3'b100, id});
        fw.push_back({7'b1010000, ch});
        fw.push_back({3'b110, (kind == 3) ? 5'd0 : 5'(len)});
        n = (kind == 3) ? 0 : (len * 8 + 6) / 7;
        bad_pos = (n > 0) ? int'($urandom_range(0, n - 1)) : 0;
        cs = 7'd0;
        for (int j = 0; j < n; j++) begin
            b = pay[7*j +: 7];
            cs ^= b;
            if (kind == 4 && j == bad_pos) fw.push_back({3'b111, ~id});
            else fw.push_back({1'b0, b});
        end
        fw.push_back({1'b0, (kind == 1) ? (cs ^ 7'd1) : cs});
        fw.push_back({3'b111, (kind == 2) ? (id ^ 5'd1) : id});
        mask = ~({256{1'b1}} << (len * 8));
        fw_word = {5'(len), pay & mask};
    endtask

    task automatic model_frame(input int kind, input int ch, input int pop_ch,
                               output int e_ok, output int e_err);
        logic [2:0] code;
        code = 3'd0;
        e_ok = 0;
        if (pop_ch >= 0 && exp_q[pop_ch].size() > 0) void'(exp_q[pop_ch].pop_front());
        case (kind)
            0: if (exp_q[ch].size() < DEPTH) begin
                   exp_q[ch].push_back(fw_word);
                   e_ok = 1;
               end else code = 3'd5;
            1: code = 3'd3;
            2: code = 3'd4;
            3: code = 3'd2;
            default: code = 3'd1;
        endcase
        e_err = (code != 3'd0) ? 1 : 0;
        if (code != 3'd0) begin
            exp_code = code;
            if (exp_drop < 65535) exp_drop++;
        end
    endtask

    task automatic run_frame(input string tag, input int kind, input int ch, input int pop_ch);
        int e_ok;
        int e_err;
        int o_ok;
        int o_err;
        logic [255:0] pay;
        for (int i = 0; i < 8; i++) pay[32*i +: 32] = $urandom;
        build_frame(kind, 5'($urandom_range(0, 31)), ch[0], int'($urandom_range(1, MAX_LEN)), pay);
        model_frame(kind, ch, pop_ch, e_ok, e_err);
        send_seq(pop_ch, o_ok, o_err);
        chk({tag, "_ok_pulses"}, o_ok, e_ok);
        chk({tag, "_err_pulses"}, o_err, e_err);
        check_outputs(tag);
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_readable", readable, 2'b00);
        chk("reset_frame_ok", frame_ok, 1'b0);
        chk("reset_frame_err", frame_err, 1'b0);
        chk("reset_err_code", err_code, 3'd0);
        chk("reset_drop_count", drop_count, 16'd0);
        chk("reset_state_idle", dbg_state, 3'd0);
        RST = 1'b1;

        fw = '{8'h81, 8'hA1, 8'hC4, 8'h6F, 8'h7D, 8'h36, 8'h75, 8'h0D, 8'h5C, 8'hE1};
        send_seq(-1, n_ok, n_err);
        chk("good_ok_pulses", n_ok, 1);
        chk("good_err_pulses", n_err, 0);
        exp_q[1].push_back({5'd4, 256'hDEADBEEF});
        check_outputs("good");
        pop_chan(1);
        check_outputs("good_popped");

        fw = '{8'h81, 8'hA1, 8'hC4, 8'h6F, 8'h7D, 8'h36, 8'h75, 8'h0D, 8'h5D, 8'hE1};
        send_seq(-1, n_ok, n_err);
        chk("csum_ok_pulses", n_ok, 0);
        chk("csum_err_pulses", n_err, 1);
        exp_code = 3'd3;
        exp_drop = 1;
        check_outputs("csum");

        fw = '{8'h81, 8'hA1, 8'hC4, 8'h6F, 8'h7D, 8'h36, 8'h75, 8'h0D, 8'h5C, 8'hE2};
        send_seq(-1, n_ok, n_err);
        chk("id_err_pulses", n_err, 1);
        exp_code = 3'd4;
        exp_drop = 2;
        check_outputs("id");

        fw = '{8'h81, 8'hA1, 8'hC0};
        send_seq(-1, n_ok, n_err);
        chk("len0_err_pulses", n_err, 1);
        chk("len0_state_idle", dbg_state, 3'd0);
        exp_code = 3'd2;
        exp_drop = 3;
        check_outputs("len0");

        fw = '{8'h81, 8'hA1, 8'h82, 8'hA1, 8'hC4, 8'h6F, 8'h7D, 8'h36, 8'h75, 8'h0D, 8'h5C, 8'hE2};
        send_seq(-1, n_ok, n_err);
        chk("resync_ok_pulses", n_ok, 1);
        chk("resync_err_pulses", n_err, 1);
        exp_code = 3'd1;
        exp_drop = 4;
        exp_q[1].push_back({5'd4, 256'hDEADBEEF});
        check_outputs("resync");
        pop_chan(1);

        for (int f = 0; f < DEPTH; f++) run_frame("fill", 0, 0, -1);
        run_frame("overflow", 0, 0, -1);
        chk("overflow_code", err_code, 3'd5);
        run_frame("pop_on_end", 0, 0, 0);
        while (exp_q[0].size() > 0) begin
            check_outputs("drain");
            pop_chan(0);
        end
        check_outputs("drained");

        run_frame("pre_reset", 0, 1, -1);
        fw = '{8'h81, 8'hA1, 8'hC4, 8'h6F};
        send_seq(-1, n_ok, n_err);
        chk("midreset_pulses", n_ok + n_err, 0);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        chk("midreset_readable", readable, 2'b00);
        chk("midreset_frame_ok", frame_ok, 1'b0);
        chk("midreset_frame_err", frame_err, 1'b0);
        chk("midreset_err_code", err_code, 3'd0);
        chk("midreset_drop_count", drop_count, 16'd0);
        chk("midreset_state_idle", dbg_state, 3'd0);
        RST = 1'b1;
        for (int k = 0; k < CHANNEL; k++) exp_q[k].delete();
        exp_code = 3'd0;
        exp_drop = 0;
        fw = '{8'h81, 8'hA1, 8'hC4, 8'h6F, 8'h7D, 8'h36, 8'h75, 8'h0D, 8'h5C, 8'hE1};
        send_seq(-1, n_ok, n_err);
        chk("after_reset_ok_pulses", n_ok, 1);
        exp_q[1].push_back({5'd4, 256'hDEADBEEF});
        check_outputs("after_reset");

        for (int f = 0; f < 40; f++) begin
            int kind;
            int pop_ch;
            kind = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 4));
            pop_ch = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : -1;
            run_frame("rand", kind, int'($urandom_range(0, 1)), pop_ch);
            for (int k = 0; k < CHANNEL; k++) begin
                if ($urandom_range(0, 2) == 0) begin
                    pop_chan(k);
                    check_outputs("rand_pop");
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
